// File: rtl/branch_resolver.sv
// Commit-side branch resolver: queues predicted control transfers from fetch, matches
// them against in-order ROB resolutions, trains the predictor and flushes on mispredicts.
module branch_resolver #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             fet_valid,
  input  logic [31:0]      fet_pc,
  input  logic             fet_pred_taken,
  input  logic [31:0]      fet_pred_pc,
  output logic             fet_full,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t state, state_next;

  // Only the predictor index and predicted next PC are needed at resolution time;
  // the predicted direction is implied by pred_pc, so it is not stored.
  logic [IDX_W-1:0] q_idx     [DEPTH];
  logic [31:0]      q_pred_pc [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic pop, push, mispred;

  logic unused_bits;
  assign unused_bits = ^{fet_pred_taken, fet_pc[31:IDX_W+2], fet_pc[1:0]};

  assign fet_full = (count == CNT_W'(DEPTH));

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mispred    = 1'b0;
    push       = 1'b0;
    case (state)
      RUN: begin
        pop     = rdy && res_valid && (count != '0);
        mispred = pop && (q_pred_pc[head] != res_target);
        push    = rdy && fet_valid && !fet_full && !mispred;
        if (mispred) state_next = FLUSH;
      end
      FLUSH: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_en      <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      upd_target  <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      mispred_cnt <= '0;
    end else if (rdy) begin
      state  <= state_next;
      upd_en <= pop;
      flush  <= mispred;
      if (pop) begin
        upd_index  <= q_idx[head];
        upd_taken  <= res_taken;
        upd_target <= res_target;
      end
      if (mispred) begin
        redirect_pc <= res_target;
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)  head <= head + PTR_W'(1);
        if (push) tail <= tail + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end else begin
      upd_en <= 1'b0;
      flush  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_idx[tail]     <= fet_pc[IDX_W+1:2];
      q_pred_pc[tail] <= fet_pred_pc;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 8;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             fet_valid = 1'b0;
  logic [31:0]      fet_pc = '0;
  logic             fet_pred_taken = 1'b0;
  logic [31:0]      fet_pred_pc = '0;
  logic             fet_full;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic [31:0]      res_target = '0;
  logic             upd_en;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [31:0]      mispred_cnt;

  branch_resolver #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fet_valid(fet_valid), .fet_pc(fet_pc), .fet_pred_taken(fet_pred_taken),
    .fet_pred_pc(fet_pred_pc), .fet_full(fet_full),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ppc;
  } rec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [31:0]      target;
    logic             fl;
  } exp_t;

  rec_t        m_q[$];
  exp_t        sb[$];
  logic        m_flush_state = 1'b0;
  logic [31:0] m_mis = '0;
  int          n_exp = 0;
  int          n_upd = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_ppc();
    return (m_q.size() > 0) ? m_q[0].ppc : 32'h0;
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the coming edge.
  task automatic step(input logic r, input logic rd, input logic fv, input logic [31:0] pc,
                      input logic [31:0] ppc, input logic rv, input logic rt,
                      input logic [31:0] rtg);
    exp_t e;
    rec_t n;
    logic was_full;
    @(negedge clk);
    chk("fet_full", {31'd0, fet_full}, {31'd0, m_q.size() == DEPTH});
    chk("mispred_cnt", mispred_cnt, m_mis);
    rst = r; rdy = rd; fet_valid = fv; fet_pc = pc; fet_pred_pc = ppc;
    fet_pred_taken = (ppc != pc + 32'd4);
    res_valid = rv; res_taken = rt; res_target = rtg;
    if (r) begin
      m_q.delete(); m_flush_state = 1'b0; m_mis = '0;
    end else if (rd) begin
      if (m_flush_state) begin
        m_flush_state = 1'b0;
      end else begin
        was_full = (m_q.size() == DEPTH);
        if (rv && m_q.size() > 0) begin
          e.idx = m_q[0].pc[IDX_W+1:2];
          e.taken = rt;
          e.target = rtg;
          e.fl = (m_q[0].ppc != rtg);
          sb.push_back(e);
          n_exp++;
          void'(m_q.pop_front());
          if (e.fl) begin
            m_q.delete();
            if (m_mis != 32'hFFFF_FFFF) m_mis++;
            m_flush_state = 1'b1;
          end
        end
        if (!m_flush_state && fv && !was_full) begin
          n.pc = pc; n.ppc = ppc;
          m_q.push_back(n);
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (upd_en) begin
      n_upd++;
      if (sb.size() == 0) begin
        chk("upd_en_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("upd_index", {24'd0, upd_index}, {24'd0, e.idx});
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
        chk("upd_target", upd_target, e.target);
        chk("flush", {31'd0, flush}, {31'd0, e.fl});
        if (e.fl) chk("redirect_pc", redirect_pc, e.target);
      end
    end else if (flush) begin
      chk("flush_without_upd", 32'd1, 32'd0);
    end
  end

  initial begin
    logic [31:0] pc, ppc, tgt;
    logic        fv, rv, rd, rr;
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
    chk("rst_upd_index", {24'd0, upd_index}, 32'd0);
    chk("rst_upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("rst_upd_target", upd_target, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    chk("rst_fet_full", {31'd0, fet_full}, 32'd0);

    // correct taken branch
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h140, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h140);
    idle(); idle();
    // mispredict, push during FLUSH ignored, push after accepted
    step(1'b0, 1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h280);
    step(1'b0, 1'b1, 1'b1, 32'h300, 32'h304, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h400, 32'h404, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, head_ppc());
    idle();
    // fill, overflow push, push+pop when full
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(i) * 4, 32'h1000 + 32'(i) * 4 + 4, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h2000, 32'h2004, 1'b1, 1'b0, head_ppc());
    idle();
    while (m_q.size() > 0) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, head_ppc());
    idle();
    // mispredict on oldest of three with concurrent push, then resolve on empty
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 32'h3000 + 32'(i) * 4, 32'h3100, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h3500, 32'h3504, 1'b1, 1'b1, 32'h3200);
    idle();
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h3100);
    idle();
    // 12 push/pop pairs across the wrap
    step(1'b0, 1'b1, 1'b1, 32'h4000, 32'h4004, 1'b0, 1'b0, '0);
    for (int i = 1; i < 12; i++)
      step(1'b0, 1'b1, 1'b1, 32'h4000 + 32'(i) * 4, 32'h4004 + 32'(i) * 4, 1'b1, 1'b0, head_ppc());
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, head_ppc());
    idle();
    // rdy low freezes resolution
    step(1'b0, 1'b1, 1'b1, 32'h5000, 32'h5040, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h5040);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h5040);
    idle(); idle();

    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) != 0);
      fv  = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 1) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      ppc = $urandom_range(0, 1) ? pc + 32'd4 : (pc + ($urandom & 32'h0000_0FFC));
      tgt = ($urandom_range(0, 7) == 0) ? head_ppc() + 32'd8 : head_ppc();
      step(rr, rd, fv, pc, ppc, rv, (tgt != 32'd0), tgt);
    end
    idle(); idle(); idle();
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("upd_pulse_total", n_upd, n_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
